transport_ctrl: RTL and testbench

Music-player transport controller. Sits directly downstream of the key debouncers: it consumes their debounced key pulses (play/pause, stop, next, prev) and the sequencer's end-of-song indication. It keeps the play/pause/stop state and the current track index, and commands the note sequencer with a run level and a one-cycle restart pulse.

---
 rtl/transport_ctrl_if.sv | 24 ++
 rtl/transport_ctrl.sv | 99 +++++++++
 tb/tb_transport_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/transport_ctrl_if.sv
// rtl/transport_ctrl_if.sv - key/song_end inputs and transport outputs of transport_ctrl
interface transport_ctrl_if #(
    parameter int TW = 2
);
    logic          p_play;
    logic          p_stop;
    logic          p_next;
    logic          p_prev;
    logic          song_end;
    logic [TW-1:0] track;
    logic          playing;
    logic          paused;
    logic          seq_start;

    modport master (
        output p_play, p_stop, p_next, p_prev, song_end,
        input  track, playing, paused, seq_start
    );

    modport slave (
        input  p_play, p_stop, p_next, p_prev, song_end,
        output track, playing, paused, seq_start
    );
endinterface

// File: rtl/transport_ctrl.sv
// rtl/transport_ctrl.sv - play/pause/stop transport and track index; TRANSPORT_REPEAT_EN wraps at last track
module transport_ctrl #(
    parameter int N_TRACKS = 4,
    parameter int TW       = 2
) (
    input  logic            clk,
    input  logic            rst,
    transport_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [TW-1:0] LAST = TW'(N_TRACKS - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] track_q, track_d;
    logic          pend_q, pend_d;
    logic          start_q, start_d;
    logic [4:0]    prev_q, prev_d;
    logic [4:0]    in_now;
    logic [4:0]    ev;
    logic          ev_play, ev_stop, ev_next, ev_prev, ev_end;
    logic [TW-1:0] track_up, track_dn;

    assign in_now  = {bus.song_end, bus.p_prev, bus.p_next, bus.p_stop, bus.p_play};
    assign prev_d  = in_now;
    assign ev      = in_now & ~prev_q;
    assign ev_play = ev[0];
    assign ev_stop = ev[1];
    assign ev_next = ev[2];
    assign ev_prev = ev[3];
    assign ev_end  = ev[4];

    assign track_up = (track_q == LAST) ? '0 : track_q + 1'b1;
    assign track_dn = (track_q == '0) ? LAST : track_q - 1'b1;

    // Strict priority: the highest event present acts even when this state ignores it.
    always_comb begin
        state_d = state_q;
        track_d = track_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        if (ev_stop) begin
            state_d = ST_STOP;
            pend_d  = 1'b0;
        end else if (ev_play) begin
            case (state_q)
                ST_STOP: begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                end
                ST_PLAY: state_d = ST_PAUSE;
                default: begin
                    state_d = ST_PLAY;
                    start_d = pend_q;
                    pend_d  = 1'b0;
                end
            endcase
        end else if (ev_next || ev_prev) begin
            if (ev_next != ev_prev) begin
                track_d = ev_next ? track_up : track_dn;
                if (state_q == ST_PLAY) start_d = 1'b1;
                if (state_q == ST_PAUSE) pend_d = 1'b1;
            end
        end else if (ev_end && state_q == ST_PLAY) begin
            track_d = track_up;
`ifdef TRANSPORT_REPEAT_EN
            start_d = 1'b1;
`else
            if (track_q == LAST) state_d = ST_STOP;
            else                 start_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOP;
            track_q <= '0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            prev_q  <= '1;
        end else begin
            state_q <= state_d;
            track_q <= track_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            prev_q  <= prev_d;
        end
    end

    assign bus.track     = track_q;
    assign bus.playing   = (state_q == ST_PLAY);
    assign bus.paused    = (state_q == ST_PAUSE);
    assign bus.seq_start = start_q;
endmodule

// File: tb/tb_transport_ctrl.sv
// tb/tb_transport_ctrl.sv - scoreboard bench for transport_ctrl
module tb_transport_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] exp_q[$];

    transport_ctrl_if #(.TW(2)) bus ();

    transport_ctrl #(.N_TRACKS(4), .TW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // expected word: {track[1:0], playing, paused, seq_start}
    task automatic step(input logic pl, input logic st, input logic nx, input logic pv,
                        input logic se, input logic [1:0] t, input logic ply,
                        input logic pau, input logic ss);
        @(negedge clk);
        bus.p_play   = pl;
        bus.p_stop   = st;
        bus.p_next   = nx;
        bus.p_prev   = pv;
        bus.song_end = se;
        exp_q.push_back({t, ply, pau, ss});
    endtask

    task automatic idle(input logic [1:0] t, input logic ply, input logic pau);
        step(0, 0, 0, 0, 0, t, ply, pau, 0);
    endtask

    initial begin : monitor
        logic [4:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.track, bus.playing, bus.paused, bus.seq_start};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_out got=%b want=%b (track,playing,paused,seq_start) at %0t", a, e, $time);
                end
            end
        end
    end

    initial begin : driver
        logic [4:0] a;
        int n;
        bus.p_play = 0; bus.p_stop = 0; bus.p_next = 0; bus.p_prev = 0; bus.song_end = 0;
        @(negedge clk);
        rst = 1'b1;
        idle(0, 0, 0);
        // held play: one event only
        step(1, 0, 0, 0, 0, 0, 1, 0, 1);
        repeat (4) step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(0, 1, 0);
        // walk to track 3 while playing
        step(0, 0, 1, 0, 0, 1, 1, 0, 1); idle(1, 1, 0);
        step(0, 0, 1, 0, 0, 2, 1, 0, 1); idle(2, 1, 0);
        step(0, 0, 1, 0, 0, 3, 1, 0, 1); idle(3, 1, 0);
`ifdef TRANSPORT_REPEAT_EN
        step(0, 0, 0, 0, 1, 0, 1, 0, 1); idle(0, 1, 0);
`else
        step(0, 0, 0, 0, 1, 0, 0, 0, 0); idle(0, 0, 0);
`endif
        step(0, 1, 0, 0, 0, 0, 0, 0, 0); idle(0, 0, 0);
        // STOP: prev wraps, no seq_start
        step(0, 0, 0, 1, 0, 3, 0, 0, 0); idle(3, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0); idle(0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0, 0); idle(1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 1); idle(1, 1, 0);
        // PAUSE on track 1, two nexts then resume with start
        step(1, 0, 0, 0, 0, 1, 0, 1, 0); idle(1, 0, 1);
        step(0, 0, 1, 0, 0, 2, 0, 1, 0); idle(2, 0, 1);
        step(0, 0, 1, 0, 0, 3, 0, 1, 0); idle(3, 0, 1);
        step(1, 0, 0, 0, 0, 3, 1, 0, 1); idle(3, 1, 0);
        // pause/resume without track change: no start
        step(1, 0, 0, 0, 0, 3, 0, 1, 0); idle(3, 0, 1);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0); idle(3, 1, 0);
        step(0, 0, 0, 1, 0, 2, 1, 0, 1); idle(2, 1, 0);
        // stop+play+next together: stop wins
        step(1, 1, 1, 0, 0, 2, 0, 0, 0); idle(2, 0, 0);
        step(1, 0, 0, 0, 0, 2, 1, 0, 1); idle(2, 1, 0);
        // next+prev cancel and mask song_end
        step(0, 0, 1, 1, 1, 2, 1, 0, 0); idle(2, 1, 0);
        step(0, 0, 0, 0, 1, 3, 1, 0, 1); idle(3, 1, 0);
        // back-to-back events on different inputs
        step(0, 0, 0, 1, 0, 2, 1, 0, 1);
        step(0, 0, 1, 0, 0, 3, 1, 0, 1);
        step(0, 0, 0, 1, 0, 2, 1, 0, 1);
        idle(2, 1, 0);
        // async reset mid-play on track 2, play held across release
        @(negedge clk);
        rst = 1'b0;
        bus.p_play = 1'b1;
        #1;
        a = {bus.track, bus.playing, bus.paused, bus.seq_start};
        checks++;
        if (a !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got=%b want=00000", a);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(0, 1, 0);
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
